// File: rtl/pin_sched_pkg.sv
// Shared types and constants for the nibble-pin frame scheduler.
package pin_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam int NIBBLES_PER_WORD = 4;
    localparam int WORD_W           = 16;
    localparam int PIN_W            = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, scanning upward with wrap.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [PTR_W-1:0] grant_idx
);

    logic [2*N-1:0] req_dbl;

    assign req_dbl = {req, req};

    // Descending scan so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_dbl[int'(ptr) + i]) begin
                if (int'(ptr) + i >= N) begin
                    grant_idx = PTR_W'(int'(ptr) + i - N);
                end else begin
                    grant_idx = PTR_W'(int'(ptr) + i);
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int j = 0; j < N; j++) begin
            if ((|req) && (int'(grant_idx) == j)) begin
                grant_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_slot_scheduler.sv
// Demand-driven, back-pressured sharing of one 4-bit pin group among N word sources.
// Each granted word goes out as a 5-nibble frame: channel-ID header, then data MS nibble first.
module pin_slot_scheduler
    import pin_sched_pkg::*;
#(
    parameter int N_SIGNALS = 4,
    parameter int ID_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_SIGNALS-1:0]    req_valid,
    input  logic [16*N_SIGNALS-1:0] req_data,
    output logic [N_SIGNALS-1:0]    req_ready,
    output logic [3:0]              pin_out,
    output logic                    pin_valid,
    output logic                    pin_sof,
    input  logic                    pin_ready,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    localparam int PTR_W = (N_SIGNALS > 1) ? $clog2(N_SIGNALS) : 1;

    // Handshakes: a word moves when req_valid[i] & req_ready[i] at a clock edge; a nibble
    // moves when pin_valid & pin_ready. Offered values never change until they are taken.
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [1:0]         nib_idx_q;
    logic [WORD_W-1:0]  shift_q;
    logic [ID_W-1:0]    id_q;
    logic [15:0]        frame_cnt_q;

    logic [N_SIGNALS-1:0] grant_onehot;
    logic [PTR_W-1:0]     grant_idx;
    logic                 take;
    logic                 last_nibble;

    rr_arbiter #(.N(N_SIGNALS), .PTR_W(PTR_W)) u_arb (
        .req          (req_valid),
        .ptr          (rr_ptr_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign req_ready   = (state_q == IDLE && en) ? grant_onehot : '0;
    assign take        = |(req_valid & req_ready);
    assign last_nibble = (nib_idx_q == 2'(NIBBLES_PER_WORD - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = HEADER;
            HEADER:  if (pin_ready) state_d = DATA;
            DATA:    if (pin_ready && last_nibble) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            nib_idx_q   <= '0;
            shift_q     <= '0;
            id_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        shift_q   <= req_data[WORD_W*grant_idx +: WORD_W];
                        id_q      <= ID_W'(grant_idx);
                        nib_idx_q <= '0;
                        rr_ptr_q  <= (int'(grant_idx) == N_SIGNALS - 1) ? '0 : grant_idx + 1'b1;
                    end
                end
                HEADER: begin
                    if (pin_ready) nib_idx_q <= '0;
                end
                DATA: begin
                    if (pin_ready) begin
                        shift_q <= shift_q << PIN_W;
                        if (last_nibble) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            nib_idx_q <= nib_idx_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pin side is Moore: only registered state, ID and word feed it.
    always_comb begin
        pin_out   = '0;
        pin_valid = 1'b0;
        pin_sof   = 1'b0;
        case (state_q)
            HEADER: begin
                pin_out   = id_q[PIN_W-1:0];
                pin_valid = 1'b1;
                pin_sof   = 1'b1;
            end
            DATA: begin
                pin_out   = shift_q[WORD_W-1 -: PIN_W];
                pin_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pin_slot_scheduler.sv
// Bench for pin_slot_scheduler: vector table, hand-written corner sequences, random run vs model.
module tb_pin_slot_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [16*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [3:0]    pin_out;
    logic          pin_valid;
    logic          pin_sof;
    logic          pin_ready;
    logic          busy;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    pin_slot_scheduler #(.N_SIGNALS(N), .ID_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pin_out   (pin_out),
        .pin_valid (pin_valid),
        .pin_sof   (pin_sof),
        .pin_ready (pin_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [63:0] data;
        logic [3:0]  exp_ready;
        logic [19:0] exp_frame;
    } vec_t;

    vec_t vecs[6];

    // Reference model: pending frame as a queue of {sof, nibble}, plus pointer and count.
    logic [4:0]  mq[$];
    int          m_ptr;
    logic [15:0] m_cnt;

    logic [19:0] frame;
    int          nacc;
    logic [5:0]  prev;
    logic [7:0]  pr_pat;
    logic [3:0]  hdr_id[5];
    int          hdr_cyc[5];
    int          nh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
        pin_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mq.delete();
        m_ptr = 0;
        m_cnt = 16'd0;
    endtask

    task automatic model_step();
        int         gi;
        bit         idle;
        logic [3:0] exp_ready;
        logic [15:0] word;
        gi = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (gi < 0 && req_valid[c]) gi = c;
        end
        idle      = (mq.size() == 0);
        exp_ready = (idle && en && gi >= 0) ? 4'(1 << gi) : 4'd0;
        chk("rand_req_ready", req_ready, exp_ready);
        chk("rand_pin_valid", pin_valid, !idle);
        chk("rand_pin_sof", pin_sof, idle ? 1'b0 : mq[0][4]);
        chk("rand_pin_out", pin_out, idle ? 4'd0 : mq[0][3:0]);
        chk("rand_busy", busy, !idle);
        chk("rand_frame_cnt", frame_cnt, m_cnt);
        if (idle) begin
            if (exp_ready != 4'd0) begin
                word = req_data[16*gi +: 16];
                mq.push_back({1'b1, 4'(gi)});
                for (int k = 3; k >= 0; k--) mq.push_back({1'b0, word[4*k +: 4]});
                m_ptr = (gi + 1) % N;
            end
        end else if (pin_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_cnt = m_cnt + 16'd1;
        end
    endtask

    initial begin
        vecs[0] = '{4'b0100, 64'h0000_A5C3_0000_0000, 4'b0100, 20'h2A5C3};
        vecs[1] = '{4'b0001, 64'h0000_0000_0000_1234, 4'b0001, 20'h01234};
        vecs[2] = '{4'b1010, 64'h7777_0000_BEEF_0000, 4'b0010, 20'h1BEEF};
        vecs[3] = '{4'b1000, 64'h0F0F_0000_0000_0000, 4'b1000, 20'h30F0F};
        vecs[4] = '{4'b1100, 64'h7777_9ABC_0000_0000, 4'b0100, 20'h29ABC};
        vecs[5] = '{4'b1111, 64'h4444_3333_2222_1111, 4'b0001, 20'h01111};

        do_reset();
        @(negedge clk);
        chk("reset_pin_valid", pin_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_pin_out", pin_out, 0);

        // Single-frame vectors, each from a fresh reset (pointer at 0).
        for (int v = 0; v < 6; v++) begin
            do_reset();
            en = 1'b1; pin_ready = 1'b1;
            req_valid = vecs[v].vld; req_data = vecs[v].data;
            @(negedge clk);
            chk("tbl_req_ready", req_ready, vecs[v].exp_ready);
            chk("tbl_idle_valid", pin_valid, 0);
            @(posedge clk); #1;
            frame = '0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("tbl_sof", pin_sof, k == 0);
                chk("tbl_valid", pin_valid, 1);
                chk("tbl_ready_low", req_ready, 0);
                frame = {frame[15:0], pin_out};
                @(posedge clk); #1;
            end
            req_valid = '0;
            chk("tbl_frame", frame, vecs[v].exp_frame);
            @(negedge clk);
            chk("tbl_frame_cnt", frame_cnt, 1);
            chk("tbl_busy_idle", busy, 0);
        end

        // Fairness: all valid, headers rotate with a 6-cycle period.
        do_reset();
        en = 1'b1; pin_ready = 1'b1; req_valid = 4'hF;
        req_data = 64'h4444_3333_2222_1111;
        nh = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (pin_sof && nh < 5) begin
                hdr_id[nh] = pin_out; hdr_cyc[nh] = cyc; nh++;
            end
            @(posedge clk); #1;
        end
        chk("fair_headers_seen", nh, 5);
        for (int i = 0; i < nh; i++) begin
            chk("fair_hdr_id", hdr_id[i], i % 4);
            if (i > 0) chk("fair_period", hdr_cyc[i] - hdr_cyc[i-1], 6);
        end

        // Back-pressure: stalls hold the pin outputs, nibble order intact.
        do_reset();
        en = 1'b1; pin_ready = 1'b1; req_valid = 4'b1000;
        req_data = 64'h9E1D_0000_0000_0000;
        @(negedge clk); @(posedge clk); #1;
        req_valid = '0;
        pr_pat = 8'b1011_0011;
        frame = '0; nacc = 0; prev = '0;
        for (int c = 0; c < 8; c++) begin
            pin_ready = pr_pat[c];
            @(negedge clk);
            if (c > 0 && !pr_pat[c-1]) chk("bp_hold", {pin_valid, pin_sof, pin_out}, prev);
            prev = {pin_valid, pin_sof, pin_out};
            if (pin_valid && pin_ready) begin
                frame = {frame[15:0], pin_out}; nacc++;
            end
            @(posedge clk); #1;
        end
        chk("bp_frame", frame, 20'h39E1D);
        chk("bp_count", nacc, 5);
        @(negedge clk);
        chk("bp_frame_cnt", frame_cnt, 1);

        // Sample-and-hold: source word changes right after the transfer.
        do_reset();
        en = 1'b1; pin_ready = 1'b1; req_valid = 4'b0010;
        req_data = 64'h0000_0000_1357_0000;
        @(negedge clk); @(posedge clk); #1;
        req_valid = '0; req_data = 64'h0000_0000_FFFF_0000;
        frame = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            frame = {frame[15:0], pin_out};
            @(posedge clk); #1;
        end
        chk("hold_frame", frame, 20'h11357);

        // Reset during DATA index 2, then a fresh grant from channel 0.
        do_reset();
        en = 1'b1; pin_ready = 1'b1; req_valid = 4'b0100;
        req_data = 64'h0000_A5C3_0000_0000;
        @(negedge clk); @(posedge clk); #1;
        req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_pre_nibble", pin_out, 4'hC);
        #1 reset = 1'b1;
        #1;
        chk("rst_pin_valid", pin_valid, 0);
        chk("rst_pin_sof", pin_sof, 0);
        chk("rst_pin_out", pin_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 4'hF; req_data = 64'h4444_3333_2222_1111;
        @(negedge clk);
        chk("rst_no_partial", pin_valid, 0);
        chk("rst_grant_ch0", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("rst_new_sof", pin_sof, 1);
        chk("rst_new_hdr", pin_out, 0);
        repeat (6) @(posedge clk);
        #1;

        // Enable low blocks grants; dropping en mid-frame does not stop the frame.
        do_reset();
        en = 1'b0; pin_ready = 1'b1; req_valid = 4'hF;
        req_data = 64'h4444_3333_2222_1111;
        repeat (4) begin
            @(negedge clk);
            chk("en_req_ready", req_ready, 0);
            chk("en_pin_valid", pin_valid, 0);
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        en = 1'b0; req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("en_frame_done", frame_cnt, 1);
        chk("en_busy", busy, 0);

        // frame_cnt wraps from 0xFFFF to 0.
        do_reset();
        en = 1'b1; pin_ready = 1'b1;
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        @(negedge clk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        @(posedge clk); #1;
        req_valid = 4'b0001; req_data = 64'h0000_0000_0000_CAFE;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("wrap_frame_cnt", frame_cnt, 16'h0000);
        chk("wrap_busy", busy, 0);

        // Random traffic against the queue model.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            en        = ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom_range(0, 15));
            req_data  = {$urandom, $urandom};
            pin_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_step();
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pin_slot_scheduler.md
Name: pin_slot_scheduler

Overview:
- Shares one 4-bit output pin group among N_SIGNALS 16-bit word sources.
- A round-robin arbiter picks a requester and latches its word, then serializes it as a 5-nibble frame: 1 header nibble carrying the channel ID, then 4 data nibbles, MS nibble first.
- Sits between the per-channel AMDF result registers and the chip-level nibble pins.
- Replaces free-running slot rotation with demand-driven, back-pressured scheduling.

Parameters:
- N_SIGNALS, 4: number of requesting channels; legal range 1..16.
- ID_W, 4: header channel-ID width; fixed at 4 (one nibble); channel index zero-extended.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  grant enable; low blocks new grants, in-flight frame completes.
- req_valid  input  N_SIGNALS  per-channel word-available flag.
- req_data  input  16*N_SIGNALS  channel i word at bits [16*i +: 16].
- req_ready  output  N_SIGNALS  one-hot acceptance; word i transfers when req_valid[i] & req_ready[i].
- pin_out  output  4  nibble on pins.
- pin_valid  output  1  pin_out holds a frame nibble.
- pin_sof  output  1  pin_out is the header nibble.
- pin_ready  input  1  downstream accepts the current nibble at this edge.
- busy  output  1  frame in flight (state != IDLE).
- frame_cnt  output  16  completed frames; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr pointer=0, nibble index=0, shift register=0, frame_cnt=0.
  - pin_out=0, pin_valid=0, pin_sof=0, busy=0, req_ready=0.
  - A frame in progress is aborted and its word discarded; no partial nibble follows reset release.
- States: IDLE, HEADER, DATA.
- IDLE:
  - req_ready = en ? grant_onehot : 0 (combinational).
  - grant_onehot = first set req_valid bit at or after rr pointer, scanning upward with wrap.
  - On transfer: latch req_data of the granted channel, latch ID = channel index, set rr pointer = (granted+1) mod N_SIGNALS, go to HEADER.
  - No req_valid set, or en=0: stay in IDLE, req_ready=0.
- HEADER:
  - pin_valid=1, pin_sof=1, pin_out=ID.
  - pin_ready=1: go to DATA with index=0. pin_ready=0: hold all outputs stable.
- DATA:
  - pin_valid=1, pin_sof=0, pin_out=word[15-4*index -: 4].
  - pin_ready=1 with index<3: index+1. pin_ready=0: hold.
  - pin_ready=1 with index==3: go to IDLE, frame_cnt+1.
- Pin outputs are Moore, driven from registered state, ID and word only; there is no combinational path from pin_ready to pin_out, pin_valid or pin_sof.
- Latency: transfer edge -> header visible next cycle. Minimum frame period is 6 cycles (1 IDLE + 5 nibbles); no back-to-back grant from DATA.
- req_data is sampled only on the transfer edge. Later changes to the source word do not affect the frame.
- A requester that drops req_valid before it is granted loses nothing and gets no grant.
- en falling mid-frame has no effect on the frame. en is checked only in IDLE.
- N_SIGNALS=1: pointer stays 0 and ID is always 0.
- All requesters valid: grants rotate 0,1,...,N-1,0; no channel waits more than N-1 frames.

Decomposition:
- Shared package pin_sched_pkg:
  - state enum {IDLE, HEADER, DATA}.
  - NIBBLES_PER_WORD=4, WORD_W=16, PIN_W=4.
- Sub-module rr_arbiter #(N):
  - Inputs req[N], ptr.
  - Output grant_onehot and grant_idx.
  - Purely combinational with a double-width wrap scan; the pointer register stays in the parent.

Test Plan:
- Single request: req_valid=4'b0100, req_data[47:32]=16'hA5C3, pin_ready=1 -> pin_out sequence 2(sof),A,5,C,3; frame_cnt=1; req_ready[2] high exactly one cycle.
- Fairness: all four valid continuously with distinct words 16'h1111..16'h4444 -> headers 0,1,2,3,0 in order; each frame spans 6 cycles.
- Back-pressure: toggle pin_ready 1,0,0,1 during DATA -> pin_out/pin_sof/pin_valid constant during stall cycles; nibble order unchanged; no nibble duplicated or skipped.
- Sample-and-hold: change req_data of the granted channel to 16'hFFFF one cycle after the transfer -> original word still emitted.
- Reset mid-frame: assert reset during DATA index 2 -> outputs 0 in the same cycle; after release, the next grant starts at channel 0 with a fresh header; frame_cnt=0.
- Enable/wrap: en=0 with all valid -> req_ready=0, pin_valid=0. Preload frame_cnt to 0xFFFF via 65535 frames (or force), then complete one frame -> frame_cnt=0x0000.
